msrv32_integer_file: RTL and testbench
======================================

Name: msrv32_integer_file

Overview:
- 32 x 32-bit RV32I integer register file.
- Write side is driven by the write-enable generator (flush-gated rf write enable) and the write-back mux.
- Read side feeds the decode/operand stage through two asynchronous read ports.
- Provides same-cycle write-to-read bypass so that a write-back and an operand read of the same register in one cycle return the new value.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
- rs_1_addr_in  input  ADDR_W  source register 1 address.
- rs_2_addr_in  input  ADDR_W  source register 2 address.
- rd_addr_in  input  ADDR_W  destination register address.
- wr_en_in  input  1  write enable, already flush-gated upstream.
- rd_in  input  DATA_W  write-back data.
- rs_1_out  output  DATA_W  read data, port 1.
- rs_2_out  output  DATA_W  read data, port 2.

Behaviour:
- Clocking and reset are fixed: one clock, ms_riscv32_mp_clk_in; reset ms_riscv32_mp_rst_in is synchronous and active-high.
- Storage: array reg_file[0 .. 2**ADDR_W-1] of DATA_W bits.
- Reset: on a rising edge with rst high, all entries are cleared to 0.
  - Reset has priority over a write in the same cycle; that write is discarded.
- Write: on a rising edge with rst low, wr_en_in = 1 and rd_addr_in != 0, reg_file[rd_addr_in] <= rd_in. No other entry changes.
- x0 handling:
  - A write to address 0 is ignored.
  - A read of address 0 always returns 0, regardless of wr_en_in, rd_in or the stored contents.
- Read (combinational, zero latency), evaluated per port in this priority order:
  1. rst high -> output 0.
  2. Address == 0 -> output 0.
  3. wr_en_in = 1 and rd_addr_in == port address -> output rd_in (bypass).
  4. Otherwise -> output reg_file[port address].
- Reset values: rs_1_out = rs_2_out = 0 while rst is high. After reset, every read returns 0 until that register is written.
- Timing:
  - Write latency is one edge: the stored value is visible from the following cycle.
  - The bypass makes the value visible in the same cycle.
- Both ports read the same address: identical outputs, including when bypassed.
- Back-to-back writes to the same rd on consecutive cycles: the last write wins, and each cycle's bypass shows that cycle's rd_in.
- Flush: the block has no flush input. A flushed instruction arrives with wr_en_in = 0, so there is no write and no bypass.
- Reset deasserted mid-sequence: the first write takes effect on the first edge with rst low. There is no recovery state.
- Unknown or X addresses are not filtered; the bench must not drive X.

Test Plan:
- Reset: hold rst for 2 cycles with wr_en_in = 1, rd_addr_in = 5, rd_in = 0xDEADBEEF. Then read rs_1 = 5 -> rs_1_out = 0; reg 5 remains 0.
- Basic write/read: write x3 = 0x12345678. Next cycle rs_1 = 3, rs_2 = 3 -> both outputs = 0x12345678. Sweep all x1..x31 with value (0xA5000000 | index) and read each back.
- x0: wr_en_in = 1, rd_addr_in = 0, rd_in = 0xFFFFFFFF. Same cycle and next cycle, rs_1 = 0 -> 0 both times; rs_2 = 0 -> 0.
- Bypass: x7 holds 0x11111111. In one cycle drive wr_en_in = 1, rd = 7, rd_in = 0x22222222, rs_1 = 7, rs_2 = 8 -> rs_1_out = 0x22222222 in that same cycle, rs_2_out = old x8. Next cycle with wr_en_in = 0 -> rs_1_out = 0x22222222.
- Gated write: wr_en_in = 0, rd = 9, rd_in = 0xCAFEBABE, rs_1 = 9 -> rs_1_out = old x9 (0) in that cycle and after.
- Random: 10k cycles of random addresses, data and enable, with rst pulsed at random points, compared against a reference model -> zero mismatches.

Source files
------------

// File: rtl/msrv32_integer_file.sv
// RV32I integer register file: 32 x 32-bit, two async read ports,
// one synchronous write port with same-cycle write-to-read bypass.
module msrv32_integer_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              ms_riscv32_mp_clk_in,
   input  logic              ms_riscv32_mp_rst_in,
   input  logic [ADDR_W-1:0] rs_1_addr_in,
   input  logic [ADDR_W-1:0] rs_2_addr_in,
   input  logic [ADDR_W-1:0] rd_addr_in,
   input  logic              wr_en_in,
   input  logic [DATA_W-1:0] rd_in,
   output logic [DATA_W-1:0] rs_1_out,
   output logic [DATA_W-1:0] rs_2_out
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] reg_file [DEPTH];
   logic              wr_valid;

   assign wr_valid = wr_en_in && (rd_addr_in != '0);

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_file[i] <= '0;
         end
      end else if (wr_valid) begin
         reg_file[rd_addr_in] <= rd_in;
      end
   end

   // Priority: reset, x0, bypass from write-back, stored value.
   always_comb begin
      rs_1_out = reg_file[rs_1_addr_in];
      if (ms_riscv32_mp_rst_in) begin
         rs_1_out = '0;
      end else if (rs_1_addr_in == '0) begin
         rs_1_out = '0;
      end else if (wr_en_in && (rd_addr_in == rs_1_addr_in)) begin
         rs_1_out = rd_in;
      end
   end

   always_comb begin
      rs_2_out = reg_file[rs_2_addr_in];
      if (ms_riscv32_mp_rst_in) begin
         rs_2_out = '0;
      end else if (rs_2_addr_in == '0) begin
         rs_2_out = '0;
      end else if (wr_en_in && (rd_addr_in == rs_2_addr_in)) begin
         rs_2_out = rd_in;
      end
   end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed vector table, register sweep and randomized reference-model
// run for msrv32_integer_file.
module tb_msrv32_integer_file;

   logic        clk;
   logic        rst;
   logic [4:0]  rs_1_addr;
   logic [4:0]  rs_2_addr;
   logic [4:0]  rd_addr;
   logic        wr_en;
   logic [31:0] rd_data;
   logic [31:0] rs_1;
   logic [31:0] rs_2;

   int checks = 0;
   int errors = 0;

   msrv32_integer_file #(
      .DATA_W(32),
      .ADDR_W(5)
   ) dut (
      .ms_riscv32_mp_clk_in(clk),
      .ms_riscv32_mp_rst_in(rst),
      .rs_1_addr_in(rs_1_addr),
      .rs_2_addr_in(rs_2_addr),
      .rd_addr_in(rd_addr),
      .wr_en_in(wr_en),
      .rd_in(rd_data),
      .rs_1_out(rs_1),
      .rs_2_out(rs_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] d;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   logic [31:0] model [32];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [4:0] rd,
                        input logic [31:0] d, input logic [4:0] a1,
                        input logic [4:0] a2);
      @(negedge clk);
      rst       = r;
      wr_en     = we;
      rd_addr   = rd;
      rd_data   = d;
      rs_1_addr = a1;
      rs_2_addr = a2;
      #1;
   endtask

   function automatic logic [31:0] expect_rd(input logic r, input logic we,
                                             input logic [4:0] rd,
                                             input logic [31:0] d,
                                             input logic [4:0] a);
      if (r) return 32'h0;
      if (a == 5'd0) return 32'h0;
      if (we && rd == a) return d;
      return model[a];
   endfunction

   initial begin
      rst       = 1'b1;
      wr_en     = 1'b0;
      rd_addr   = '0;
      rd_data   = '0;
      rs_1_addr = '0;
      rs_2_addr = '0;

      // rst, we, rd, data, rs1, rs2, exp1, exp2
      vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'h0, 32'h0};
      vecs[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h0, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, 5'd3,  32'h12345678, 5'd3,  5'd4,  32'h12345678, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h12345678, 32'h12345678};
      vecs[5]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 5'd7,  32'h11111111, 5'd7,  5'd3,  32'h11111111, 32'h12345678};
      vecs[8]  = '{1'b0, 1'b1, 5'd8,  32'h88888888, 5'd7,  5'd8,  32'h11111111, 32'h88888888};
      vecs[9]  = '{1'b0, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd8,  32'h22222222, 32'h88888888};
      vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h22222222, 32'h22222222};
      vecs[11] = '{1'b0, 1'b0, 5'd9,  32'hCAFEBABE, 5'd9,  5'd9,  32'h0, 32'h0};
      vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd9,  5'd8,  32'h0, 32'h88888888};
      vecs[13] = '{1'b0, 1'b1, 5'd10, 32'h00000001, 5'd10, 5'd10, 32'h1, 32'h1};
      vecs[14] = '{1'b0, 1'b1, 5'd10, 32'h00000002, 5'd10, 5'd10, 32'h2, 32'h2};
      vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 32'h2, 32'h2};
      vecs[16] = '{1'b1, 1'b1, 5'd3,  32'h00000055, 5'd3,  5'd3,  32'h0, 32'h0};
      vecs[17] = '{1'b0, 1'b1, 5'd11, 32'h0000ABCD, 5'd3,  5'd11, 32'h0, 32'h0000ABCD};
      vecs[18] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd11, 5'd7,  32'h0000ABCD, 32'h0};

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].rd, vecs[i].d,
               vecs[i].a1, vecs[i].a2);
         check($sformatf("vec%0d_rs1", i), rs_1, vecs[i].e1);
         check($sformatf("vec%0d_rs2", i), rs_2, vecs[i].e2);
      end

      // Sweep x1..x31: bypass on write, then stored readback.
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 1'b1, 5'(i), 32'hA5000000 | i, 5'(i), 5'(i));
         check($sformatf("sweep_byp_x%0d", i), rs_1, 32'hA5000000 | i);
      end
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         check($sformatf("sweep_rd1_x%0d", i), rs_1, 32'hA5000000 | i);
         check($sformatf("sweep_rd2_x%0d", 31 - i), rs_2,
               (i == 31) ? 32'h0 : (32'hA5000000 | (31 - i)));
      end

      // Random run against a reference model; first cycle resets.
      for (int c = 0; c < 10000; c++) begin
         logic        r;
         logic        we;
         logic [4:0]  rd;
         logic [31:0] d;
         logic [4:0]  a1;
         logic [4:0]  a2;
         r  = (c == 0) || ($urandom_range(49) == 0);
         we = 1'($urandom_range(1));
         rd = 5'($urandom_range(31));
         d  = $urandom;
         a1 = ($urandom_range(3) == 0) ? rd : 5'($urandom_range(31));
         a2 = ($urandom_range(3) == 0) ? a1 : 5'($urandom_range(31));
         drive(r, we, rd, d, a1, a2);
         check("rand_rs1", rs_1, expect_rd(r, we, rd, d, a1));
         check("rand_rs2", rs_2, expect_rd(r, we, rd, d, a2));
         if (r) begin
            for (int k = 0; k < 32; k++) model[k] = 32'h0;
         end else if (we && rd != 5'd0) begin
            model[rd] = d;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
